// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter.
//
// Accepts a byte over a valid/ready handshake and sends it on txd. The frame
// is a start bit, DATA_BITS data bits LSB first, an optional parity bit and
// STOP_BITS stop bits. Each bit lasts CLK_FREQ/BAUD clocks.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   tx_data  in   byte to send (bits above DATA_BITS-1 ignored)
//   tx_valid in   tx_data valid, held until accepted
//   tx_ready out  registered, high when a byte can be accepted
//   txd      out  registered serial line, idles high
//   busy     out  registered, high from accept through the end of the last stop bit
//
// state    | meaning
// ---------+------------------------------------------
// S_IDLE   | line high, waiting for tx_valid
// S_START  | driving the start bit (low)
// S_DATA   | driving data bit idx from shift[0]
// S_PARITY | driving the parity bit
// S_STOP   | driving stop bit(s) (high)

module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic             stop_cnt, stop_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             acc, acc_nxt;
  logic             txd_nxt, tx_ready_nxt, busy_nxt;
  logic             bit_done;

  assign bit_done = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      acc      <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      stop_cnt <= stop_cnt_nxt;
      shift    <= shift_nxt;
      acc      <= acc_nxt;
      txd      <= txd_nxt;
      tx_ready <= tx_ready_nxt;
      busy     <= busy_nxt;
    end
  end

  // txd is registered from the current state, so the line lags the state by
  // one clock: the start bit appears one edge after the accept edge.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    stop_cnt_nxt = stop_cnt;
    shift_nxt    = shift;
    acc_nxt      = acc;
    txd_nxt      = 1'b1;

    case (state)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          shift_nxt    = tx_data & DATA_MASK;
          cnt_nxt      = '0;
          idx_nxt      = '0;
          stop_cnt_nxt = 1'b0;
          acc_nxt      = 1'b0;
          state_nxt    = S_START;
        end
      end

      S_START: begin
        txd_nxt = 1'b0;
        cnt_nxt = bit_done ? '0 : cnt + CNT_W'(1);
        if (bit_done) begin
          idx_nxt   = '0;
          state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        txd_nxt = shift[0];
        cnt_nxt = bit_done ? '0 : cnt + CNT_W'(1);
        if (bit_done) begin
          shift_nxt = shift >> 1;
          acc_nxt   = acc ^ shift[0];
          idx_nxt   = idx + 3'd1;
          if (idx == IDX_LAST) begin
            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        // acc holds the XOR of the data bits; even parity sends it as is.
        txd_nxt = (PARITY == 2) ? acc : ~acc;
        cnt_nxt = bit_done ? '0 : cnt + CNT_W'(1);
        if (bit_done) begin
          state_nxt = S_STOP;
        end
      end

      S_STOP: begin
        txd_nxt = 1'b1;
        cnt_nxt = bit_done ? '0 : cnt + CNT_W'(1);
        if (bit_done) begin
          if (stop_cnt == STOP_LAST) begin
            state_nxt = S_IDLE;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Ready returns on the edge the FSM re-enters IDLE so a held tx_valid is
    // accepted on the very next edge. busy stays up one more clock to cover
    // the last stop-bit clock still on the line.
    tx_ready_nxt = (state_nxt == S_IDLE);
    busy_nxt     = (state != S_IDLE) || (state_nxt != S_IDLE);
  end

endmodule
